// File: rtl/fetch_unit_if.sv
// Instruction-memory request/grant/response bus between the fetch stage and
// instruction memory. The fetch stage is the master; memory is the slave.
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: holds the architectural PC, fetches the word at PC
// over a request/grant/response bus, presents it downstream and loads the
// next PC on retire. Halt and misaligned next-PC values park the stage in a
// terminal state until reset.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      npc,
    input  logic             instr_ready,
    input  logic             halt,
    fetch_unit_if.master     imem,
    output logic [31:0]      pc,
    output logic [31:0]      instr,
    output logic             instr_valid,
    output logic             halted,
    output logic             misalign,
    output logic [CNT_W-1:0] retire_cnt
);

    typedef enum logic [2:0] {
        S_REQ  = 3'd0,
        S_WAIT = 3'd1,
        S_HOLD = 3'd2,
        S_HALT = 3'd3,
        S_ERR  = 3'd4
    } state_e;

    state_e           state_q,       state_d;
    logic [31:0]      pc_q,          pc_d;
    logic [31:0]      instr_q,       instr_d;
    logic             instr_valid_q, instr_valid_d;
    logic             halted_q,      halted_d;
    logic             misalign_q,    misalign_d;
    logic [CNT_W-1:0] retire_cnt_q,  retire_cnt_d;
    logic             imem_req_q,    imem_req_d;

    // Next-state and datapath update; every register holds unless its state acts.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        halted_d      = halted_q;
        misalign_d    = misalign_q;
        retire_cnt_d  = retire_cnt_q;

        case (state_q)
            S_REQ: begin
                if (imem.imem_gnt) begin
                    state_d = S_WAIT;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_WAIT: begin
                // Only responses seen while waiting are captured, so a
                // response coincident with the grant is dropped.
                if (imem.imem_rvalid) begin
                    instr_d       = imem.imem_rdata;
                    instr_valid_d = 1'b1;
                    state_d       = S_HOLD;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_HOLD: begin
                if (instr_ready) begin
                    retire_cnt_d  = retire_cnt_q + CNT_W'(1);
                    instr_valid_d = 1'b0;
                    // Halt wins over the alignment check; pc stays put.
                    if (halt) begin
                        halted_d = 1'b1;
                        state_d  = S_HALT;
                    end else if (npc[1:0] != 2'b00) begin
                        misalign_d = 1'b1;
                        state_d    = S_ERR;
                    end else begin
                        pc_d    = npc;
                        state_d = S_REQ;
                    end
                end else begin
                    state_d = S_HOLD;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            S_ERR: begin
                state_d = S_ERR;
            end
            default: begin
                // Unreachable encoding: park safely with nothing presented.
                instr_valid_d = 1'b0;
                state_d       = S_ERR;
            end
        endcase

        // Request flop tracks the state being entered so it is registered.
        imem_req_d = (state_d == S_REQ);
    end

    // State and datapath registers with synchronous reset overriding all.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_REQ;
            pc_q          <= RESET_PC;
            instr_q       <= 32'h0000_0000;
            instr_valid_q <= 1'b0;
            halted_q      <= 1'b0;
            misalign_q    <= 1'b0;
            retire_cnt_q  <= '0;
            imem_req_q    <= 1'b1;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            halted_q      <= halted_d;
            misalign_q    <= misalign_d;
            retire_cnt_q  <= retire_cnt_d;
            imem_req_q    <= imem_req_d;
        end
    end

    assign imem.imem_req  = imem_req_q;
    assign imem.imem_addr = pc_q;
    assign pc             = pc_q;
    assign instr          = instr_q;
    assign instr_valid    = instr_valid_q;
    assign halted         = halted_q;
    assign misalign       = misalign_q;
    assign retire_cnt     = retire_cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: drives inputs on the falling edge and checks
// outputs there, half a cycle after each rising edge.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] npc = 32'h0000_0000;
    logic        instr_ready = 1'b0;
    logic        halt = 1'b0;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        instr_valid;
    logic        halted;
    logic        misalign;
    logic [31:0] retire_cnt;

    int checks = 0;
    int errors = 0;

    fetch_unit_if bus ();

    fetch_unit #(
        .RESET_PC (32'h0000_3000),
        .CNT_W    (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .npc         (npc),
        .instr_ready (instr_ready),
        .halt        (halt),
        .imem        (bus.master),
        .pc          (pc),
        .instr       (instr),
        .instr_valid (instr_valid),
        .halted      (halted),
        .misalign    (misalign),
        .retire_cnt  (retire_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // Zero-wait fetch starting in REQ: grant now, data next cycle; ends in HOLD.
    task automatic fetch_zw(input logic [31:0] data);
        bus.imem_gnt = 1'b1;
        step();
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = data;
        step();
        bus.imem_rvalid = 1'b0;
    endtask

    initial begin
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0000_0000;

        // Reset state
        step();
        step();
        rst = 1'b0;
        chk("rst_pc",       pc,                 32'h0000_3000);
        chk("rst_req",      {31'd0, bus.imem_req},  32'd1);
        chk("rst_addr",     bus.imem_addr,      32'h0000_3000);
        chk("rst_instr",    instr,              32'h0000_0000);
        chk("rst_valid",    {31'd0, instr_valid}, 32'd0);
        chk("rst_halted",   {31'd0, halted},    32'd0);
        chk("rst_misalign", {31'd0, misalign},  32'd0);
        chk("rst_cnt",      retire_cnt,         32'd0);

        // Zero-wait sequential fetch: 3000, 3004, 3008, one retire per 3 cycles
        instr_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("seq_req",  {31'd0, bus.imem_req}, 32'd1);
            chk("seq_addr", bus.imem_addr, 32'h0000_3000 + 32'(i) * 32'd4);
            bus.imem_gnt = 1'b1;
            step();
            chk("seq_wait_req", {31'd0, bus.imem_req}, 32'd0);
            bus.imem_gnt    = 1'b0;
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = 32'h2408_0005;
            step();
            bus.imem_rvalid = 1'b0;
            chk("seq_valid", {31'd0, instr_valid}, 32'd1);
            chk("seq_instr", instr, 32'h2408_0005);
            npc = 32'h0000_3004 + 32'(i) * 32'd4;
            step();
        end
        chk("seq_cnt",   retire_cnt, 32'd3);
        chk("seq_pc",    pc,         32'h0000_300C);
        chk("seq_valid0", {31'd0, instr_valid}, 32'd0);

        // Delayed grant/response, grant-cycle rvalid ignored, then a branch
        instr_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            chk("dly_req",  {31'd0, bus.imem_req}, 32'd1);
            chk("dly_addr", bus.imem_addr, 32'h0000_3000);
            step();
        end
        bus.imem_gnt    = 1'b1;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'hDEAD_BEEF;
        step();
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("dly_wvalid", {31'd0, instr_valid}, 32'd0);
            chk("dly_wreq",   {31'd0, bus.imem_req}, 32'd0);
            step();
        end
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'h1111_2222;
        step();
        bus.imem_rvalid = 1'b0;
        chk("dly_valid", {31'd0, instr_valid}, 32'd1);
        chk("dly_instr", instr, 32'h1111_2222);
        step();
        step();
        chk("hold_valid", {31'd0, instr_valid}, 32'd1);
        chk("hold_cnt",   retire_cnt, 32'd0);
        npc         = 32'h0000_1000;
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        chk("br_addr", bus.imem_addr, 32'h0000_1000);
        chk("br_req",  {31'd0, bus.imem_req}, 32'd1);
        chk("br_cnt",  retire_cnt, 32'd1);

        // Misaligned next PC parks in ERR until reset
        do_reset();
        fetch_zw(32'h0000_0013);
        npc         = 32'h0000_3006;
        instr_ready = 1'b1;
        step();
        chk("mis_flag", {31'd0, misalign}, 32'd1);
        chk("mis_pc",   pc, 32'h0000_3000);
        chk("mis_cnt",  retire_cnt, 32'd1);
        bus.imem_gnt    = 1'b1;
        bus.imem_rvalid = 1'b1;
        npc             = 32'h0000_0004;
        for (int i = 0; i < 3; i++) begin
            chk("err_req",   {31'd0, bus.imem_req}, 32'd0);
            chk("err_valid", {31'd0, instr_valid}, 32'd0);
            chk("err_pc",    pc, 32'h0000_3000);
            chk("err_cnt",   retire_cnt, 32'd1);
            step();
        end
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        instr_ready     = 1'b0;
        do_reset();
        chk("err_rst_pc",  pc, 32'h0000_3000);
        chk("err_rst_mis", {31'd0, misalign}, 32'd0);
        chk("err_rst_req", {31'd0, bus.imem_req}, 32'd1);

        // Halt wins over misaligned npc
        fetch_zw(32'h0000_0013);
        npc         = 32'h0000_3001;
        halt        = 1'b1;
        instr_ready = 1'b1;
        step();
        chk("halt_flag", {31'd0, halted}, 32'd1);
        chk("halt_mis",  {31'd0, misalign}, 32'd0);
        chk("halt_pc",   pc, 32'h0000_3000);
        bus.imem_gnt    = 1'b1;
        bus.imem_rvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("halt_req", {31'd0, bus.imem_req}, 32'd0);
            chk("halt_cnt", retire_cnt, 32'd1);
            step();
        end
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        halt            = 1'b0;
        instr_ready     = 1'b0;

        // Reset during WAIT drops the late response and re-requests 3000
        do_reset();
        bus.imem_gnt = 1'b1;
        step();
        bus.imem_gnt = 1'b0;
        chk("rw_wait_req", {31'd0, bus.imem_req}, 32'd0);
        rst = 1'b1;
        step();
        rst             = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'hBAD0_BAD0;
        step();
        bus.imem_rvalid = 1'b0;
        chk("rw_valid", {31'd0, instr_valid}, 32'd0);
        chk("rw_instr", instr, 32'h0000_0000);
        chk("rw_req",   {31'd0, bus.imem_req}, 32'd1);
        chk("rw_addr",  bus.imem_addr, 32'h0000_3000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
